// File: rtl/rtlgen_pkg_v5.sv
// Shared types for the IOSF primary -> register-file config path.
// Header layout, opcodes, request/ack bundles and the header parity helper.
package rtlgen_pkg_v5;

  typedef enum logic [6:0] {
    IOSF_MRD32   = 7'h00,
    IOSF_IORD    = 7'h02,
    IOSF_CFGRD0  = 7'h04,
    IOSF_CFGRD1  = 7'h05,
    IOSF_CPL     = 7'h0A,
    IOSF_MRD64   = 7'h20,
    IOSF_MSG     = 7'h30,
    IOSF_MWR32   = 7'h40,
    IOSF_IOWR    = 7'h42,
    IOSF_CFGWR0  = 7'h44,
    IOSF_CFGWR1  = 7'h45,
    IOSF_LTMWR32 = 7'h47,
    IOSF_CPLD    = 7'h4A,
    IOSF_MWR64   = 7'h60,
    IOSF_LTMWR64 = 7'h67
  } cfg_iosf_opcode_t;

  typedef enum logic [2:0] {
    MRD   = 3'd0,
    MWR   = 3'd1,
    IORD  = 3'd2,
    IOWR  = 3'd3,
    CFGRD = 3'd4,
    CFGWR = 3'd5
  } cfg_opcode_t;

  typedef enum logic [2:0] {
    SC = 3'b000,
    UR = 3'b001
  } cfg_cpl_status_t;

  typedef struct packed {
    cfg_iosf_opcode_t opcode;
    logic [7:0]       tag;
    logic [15:0]      rqid;
    logic [9:0]       length;
    logic [3:0]       fbe;
    logic [3:0]       lbe;
    logic [63:0]      address;
  } cfg_iosf_cmd_t;

  typedef struct packed {
    logic [47:0] offset;
  } cfg_mem_addr_t;

  typedef struct packed {
    logic [31:0] pad;
    logic [15:0] offset;
  } cfg_io_addr_t;

  typedef struct packed {
    logic [35:0] pad;
    logic [11:0] offset;
  } cfg_cfg_addr_t;

  typedef union packed {
    cfg_mem_addr_t mem;
    cfg_io_addr_t  io;
    cfg_cfg_addr_t cfg;
  } cfg_addr_t;

  typedef struct packed {
    logic        valid;
    cfg_opcode_t opcode;
    cfg_addr_t   addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  sai;
    logic [7:0]  fid;
    logic [2:0]  bar;
  } cfg_req_32bit_t;

  typedef struct packed {
    logic        read_valid;
    logic        read_miss;
    logic        write_valid;
    logic        write_miss;
    logic        sai_successfull;
    logic [31:0] data;
  } cfg_ack_32bit_t;

  // Even parity: the parity bit makes the header plus parity bit even.
  function automatic logic CmdParity(input cfg_iosf_cmd_t cmd);
    return ^cmd;
  endfunction

endpackage

// File: rtl/iosf_cfg_bridge_decode.sv
// IOSF header classifier: support check, posted class and config-side
// opcode/address translation.
module iosf_cfg_decode
  import rtlgen_pkg_v5::*;
(
  input  cfg_iosf_cmd_t cmd,
  output logic          supported,
  output logic          posted,
  output logic          is_read,
  output cfg_opcode_t   cfg_opcode,
  output cfg_addr_t     cfg_addr
);
  logic len_ok;
  logic unused;

  assign len_ok = cmd.length == 10'd1;
  assign unused = ^{cmd.tag, cmd.rqid, cmd.fbe, cmd.lbe, cmd.address[63:48]};

  always_comb begin
    supported  = 1'b0;
    is_read    = 1'b0;
    cfg_opcode = MRD;
    cfg_addr   = '0;
    posted     = cmd.opcode inside {IOSF_MWR32, IOSF_MWR64,
                                    IOSF_LTMWR32, IOSF_LTMWR64};
    unique case (cmd.opcode)
      IOSF_MRD32, IOSF_MRD64: begin
        supported           = len_ok;
        is_read             = 1'b1;
        cfg_opcode          = MRD;
        cfg_addr.mem.offset = cmd.address[47:0];
      end
      IOSF_MWR32, IOSF_MWR64: begin
        supported           = len_ok;
        cfg_opcode          = MWR;
        cfg_addr.mem.offset = cmd.address[47:0];
      end
      IOSF_IORD, IOSF_IOWR: begin
        supported          = len_ok;
        is_read            = cmd.opcode == IOSF_IORD;
        cfg_opcode         = (cmd.opcode == IOSF_IORD) ? IORD : IOWR;
        cfg_addr.io.offset = cmd.address[15:0];
      end
      IOSF_CFGRD0, IOSF_CFGWR0: begin
        supported           = len_ok;
        is_read             = cmd.opcode == IOSF_CFGRD0;
        cfg_opcode          = (cmd.opcode == IOSF_CFGRD0) ? CFGRD : CFGWR;
        cfg_addr.cfg.offset = cmd.address[11:0];
      end
      default: supported = 1'b0;
    endcase
  end
endmodule

// File: rtl/iosf_cfg_bridge.sv
// Single-outstanding IOSF primary to config-target bridge with parity
// check, ack timeout and completion return for non-posted requests.
module iosf_cfg_bridge
  import rtlgen_pkg_v5::*;
#(
  parameter int TIMEOUT_CYC  = 256,
  parameter int CNT_W        = 9,
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           iosf_cmd_valid,
  output logic           iosf_cmd_ready,
  input  cfg_iosf_cmd_t  iosf_cmd,
  input  logic           iosf_cmd_parity,
  input  logic [31:0]    iosf_wdata,
  input  logic [7:0]     iosf_sai,
  input  logic [2:0]     iosf_bar,
  output cfg_req_32bit_t cfg_req,
  input  cfg_ack_32bit_t cfg_ack,
  output logic           cpl_valid,
  input  logic           cpl_ready,
  output logic [6:0]     cpl_opcode,
  output logic [2:0]     cpl_status,
  output logic [15:0]    cpl_rqid,
  output logic [7:0]     cpl_tag,
  output logic [31:0]    cpl_data,
  output logic           parity_err,
  output logic           unsup_err,
  output logic           timeout_err
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_CPL} state_t;

  state_t          state, state_n;
  logic            supported, posted, is_read;
  cfg_opcode_t     dec_op;
  cfg_addr_t       dec_addr;
  logic            accept, perr, ack, expire, go_cpl, tmo;
  logic            posted_q, is_read_q;
  logic [15:0]     rqid_q, rqid_n;
  logic [7:0]      tag_q, tag_n;
  logic [CNT_W-1:0] cnt;
  cfg_req_32bit_t  req_n;
  logic [6:0]      op_n;
  cfg_cpl_status_t st_n;
  logic [31:0]     data_n;

  iosf_cfg_decode u_dec (
    .cmd        (iosf_cmd),
    .supported  (supported),
    .posted     (posted),
    .is_read    (is_read),
    .cfg_opcode (dec_op),
    .cfg_addr   (dec_addr)
  );

  assign accept = iosf_cmd_valid && iosf_cmd_ready;
  assign perr   = CHECK_PARITY && (CmdParity(iosf_cmd) != iosf_cmd_parity);
  assign ack    = cfg_ack.read_valid | cfg_ack.read_miss |
                  cfg_ack.write_valid | cfg_ack.write_miss;
  // Fires on the last WAIT cycle so the pulse lands TIMEOUT_CYC after valid.
  assign expire = cnt == CNT_W'(TIMEOUT_CYC - 1);

  always_comb begin
    req_n       = '0;
    req_n.valid = 1'b1;
    req_n.opcode = dec_op;
    req_n.addr  = dec_addr;
    req_n.be    = iosf_cmd.fbe;
    req_n.data  = is_read ? 32'h0 : iosf_wdata;
    req_n.sai   = iosf_sai;
    req_n.fid   = iosf_cmd.rqid[7:0];
    req_n.bar   = iosf_bar;
  end

  always_comb begin
    state_n = state;
    go_cpl  = 1'b0;
    tmo     = 1'b0;
    op_n    = IOSF_CPL;
    st_n    = UR;
    data_n  = '0;
    rqid_n  = rqid_q;
    tag_n   = tag_q;
    unique case (state)
      ST_IDLE: begin
        if (accept && !perr) begin
          if (supported) begin
            state_n = ST_ISSUE;
          end else if (!posted) begin
            state_n = ST_CPL;
            go_cpl  = 1'b1;
            rqid_n  = iosf_cmd.rqid;
            tag_n   = iosf_cmd.tag;
          end
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (ack || expire) begin
          state_n = posted_q ? ST_IDLE : ST_CPL;
          go_cpl  = !posted_q;
          tmo     = !ack;
        end
        if (ack && cfg_ack.sai_successfull) begin
          if (is_read_q && cfg_ack.read_valid) begin
            op_n   = IOSF_CPLD;
            st_n   = SC;
            data_n = cfg_ack.data;
          end else if (!is_read_q && cfg_ack.write_valid) begin
            st_n = SC;
          end
        end
      end
      ST_CPL: if (cpl_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iosf_cmd_ready <= 1'b0;
      cfg_req        <= '0;
      posted_q       <= 1'b0;
      is_read_q      <= 1'b0;
      rqid_q         <= '0;
      tag_q          <= '0;
      cnt            <= '0;
      cpl_valid      <= 1'b0;
      cpl_opcode     <= '0;
      cpl_status     <= '0;
      cpl_rqid       <= '0;
      cpl_tag        <= '0;
      cpl_data       <= '0;
      parity_err     <= 1'b0;
      unsup_err      <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      iosf_cmd_ready <= state_n == ST_IDLE;
      parity_err     <= accept && perr;
      unsup_err      <= accept && !perr && !supported && posted;
      timeout_err    <= tmo;
      cfg_req.valid  <= 1'b0;
      cnt <= (state == ST_ISSUE || state == ST_WAIT) ? cnt + CNT_W'(1) : '0;
      if (accept && !perr && supported) begin
        cfg_req   <= req_n;
        posted_q  <= posted;
        is_read_q <= is_read;
        rqid_q    <= iosf_cmd.rqid;
        tag_q     <= iosf_cmd.tag;
      end
      if (go_cpl) begin
        cpl_valid  <= 1'b1;
        cpl_opcode <= op_n;
        cpl_status <= st_n;
        cpl_rqid   <= rqid_n;
        cpl_tag    <= tag_n;
        cpl_data   <= data_n;
      end else if (state == ST_CPL && cpl_ready) begin
        cpl_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/iosf_cfg_bridge.md
Name: iosf_cfg_bridge

Overview:
Upstream front end for the register-file config target. Accepts one IOSF primary command (cfg_iosf_cmd_t plus 32-bit write data) and checks its parity. Translates it into a single cfg_req_32bit_t request, waits for the matching cfg_ack_32bit_t, and returns a completion for non-posted requests. Only one transaction is in flight at a time; a timeout protects against a missing ack.

Parameters:
TIMEOUT_CYC, 256, cycles in WAIT before forcing a UR completion (>=2)
CNT_W, 9, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
CHECK_PARITY, 1, 1 enables command parity checking; 0 ignores iosf_cmd_parity

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
iosf_cmd_valid  in  1  command present
iosf_cmd_ready  out  1  command accepted when valid&&ready
iosf_cmd  in  $bits(cfg_iosf_cmd_t)  IOSF command header
iosf_cmd_parity  in  1  even parity over the header (CmdParity)
iosf_wdata  in  32  write data, 1 DW
iosf_sai  in  8  security attribute of initiator
iosf_bar  in  3  BAR hit
cfg_req  out  $bits(cfg_req_32bit_t)  request to config target
cfg_ack  in  $bits(cfg_ack_32bit_t)  response from config target
cpl_valid  out  1  completion present
cpl_ready  in  1  completion consumed
cpl_opcode  out  7  IOSF_CPL or IOSF_CPLD
cpl_status  out  3  000=SC, 001=UR
cpl_rqid  out  16  echoed rqid
cpl_tag  out  8  echoed tag
cpl_data  out  32  read data; 0 unless CPLD
parity_err  out  1  one-cycle pulse
unsup_err  out  1  one-cycle pulse
timeout_err  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE; all outputs and cfg_req fields are 0; iosf_cmd_ready is 0 during reset and 1 in the first cycle after reset.
- FSM states and transitions:
  - IDLE: iosf_cmd_ready=1. On accept at cycle T:
    - Parity error → stay IDLE; parity_err=1 at T+1; no request, no completion.
    - Supported → ISSUE.
    - Unsupported, non-posted → CPL with UR.
    - Unsupported, posted → stay IDLE; unsup_err=1 at T+1.
  - ISSUE: cfg_req.valid=1 for exactly one cycle (T+1) → WAIT. The timeout counter clears here.
  - WAIT: all cfg_req fields are held stable and valid=0. The counter increments each cycle.
    - Ack (read_valid|read_miss|write_valid|write_miss) → CPL if non-posted, else IDLE.
    - Counter reaching TIMEOUT_CYC → timeout_err pulse; CPL with UR if non-posted, else IDLE.
    - Ack in the same cycle as expiry: the ack wins and no timeout_err is raised.
  - CPL: cpl_valid=1 with all cpl fields stable until cpl_ready; on handshake → IDLE. The next command can be accepted in the cycle after the handshake.
- Parity check: error = CHECK_PARITY && (CmdParity(iosf_cmd) != iosf_cmd_parity).
- Supported commands require length==1. Mapping:
  - MRD32/MRD64→MRD
  - MWR32/MWR64→MWR
  - IORD→IORD, IOWR→IOWR
  - CFGRD0→CFGRD, CFGWR0→CFGWR
  - Everything else is unsupported, including length!=1.
- Posted classification: MWR32, MWR64, LTMWR32 and LTMWR64 are posted; all other opcodes are non-posted.
- Request fields:
  - be=fbe; data=iosf_wdata for writes, 0 for reads.
  - sai=iosf_sai; fid=rqid[7:0]; bar=iosf_bar.
  - Address by type:
    - mem.offset = address[47:0]
    - io: offset = address[15:0], pad = 0
    - cfg: offset = address[11:0], pad = 0
- Completion content:
  - Read with read_valid && sai_successfull → CPLD, SC, data = ack.data.
  - Non-posted write with write_valid && sai_successfull → CPL, SC.
  - Miss, SAI failure, timeout or unsupported → CPL, UR, data 0.
- An ack received outside WAIT is ignored (late acks after a timeout are discarded).
- Reset asserted mid-transaction: the in-flight request is abandoned with no completion and no error pulse.

Decomposition:
- Shared package rtlgen_pkg_v5 owns cfg_iosf_cmd_t, cfg_iosf_opcode_t, cfg_opcode_t, cfg_req_32bit_t, cfg_ack_32bit_t and CmdParity.
- Add to the package: cfg_cpl_status_t enum (SC=3'b000, UR=3'b001).
- One combinational sub-module, iosf_cfg_decode, produces {supported, posted, is_read, cfg_opcode, cfg_addr} from a header.

Test Plan:
- MRD32, addr 0x1000, fbe 0xF, tag 0x21; ack read_valid, sai_successfull=1, data 0xDEADBEEF → one-cycle cfg_req (MRD, mem.offset 0x1000); then CPLD, SC, data 0xDEADBEEF, tag 0x21.
- MWR64, addr 0x0000_1234_5678, wdata 0xA5A5A5A5; ack write_valid → cfg_req (MWR, offset 0x1234_5678, data 0xA5A5A5A5); no cpl_valid; iosf_cmd_ready=1 the cycle after the ack.
- CFGWR0, addr 0x0FC; ack write_miss → cfg_req (CFGWR, cfg.offset 0x0FC); then CPL, UR, data 0.
- MRD32 with parity bit inverted → parity_err pulse at T+1; cfg_req.valid stays 0; no completion.
- TIMEOUT_CYC=16, IORD with no ack → timeout_err exactly 16 cycles after cfg_req.valid; CPL UR; an ack 3 cycles later is ignored.
- Hold cpl_ready=0 for 5 cycles → cpl fields stable and iosf_cmd_ready=0 throughout. Separately, assert rst_n=0 during WAIT → all outputs 0; IDLE with ready=1 after release.
